iddr_deser: RTL and testbench
=============================

IDDR_DESER -- requirements
Module: iddr_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 10, deserialized word width (even, 4..16).
REQ-002 SHALL have parameter COMMA_TIMEOUT, default 1024, words without aligned comma before lock loss.
REQ-003 SHALL have port CLK  input  1  sample clock, same as the upstream DDR input register's C.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port DDR_Q1  input  1  rising-edge sample (earlier bit).
REQ-006 SHALL have port DDR_Q2  input  1  falling-edge sample (later bit).
REQ-007 SHALL have port RESYNC  input  1  one-cycle request to drop lock and re-search.
REQ-008 SHALL have port DATA  output  WIDTH  aligned word, first-received bit in MSB.
REQ-009 SHALL have port DATA_VALID  output  1  one-cycle strobe, DATA valid.
REQ-010 SHALL have port LOCKED  output  1  word alignment established.
REQ-011 SHALL have port LOSS_CNT  output  8  lock-loss count (see Configuration).

Function
REQ-012 SHALL shift DDR_Q1 then DDR_Q2 into a WIDTH+1 bit shift register every CLK (2 bits/cycle).
REQ-013 SHALL detect the K28.5 comma (0011111010 or 1100000101, MSB first) at both bit phases each cycle: window [WIDTH-1:0] (phase 0) and [WIDTH:1] (phase 1).
REQ-014 SHALL implement states SEARCH (reset) and LOCKED.
REQ-015 SEARCH: on comma at either phase -> LOCKED; latch phase (phase 0 wins if both); word counter cleared to 0 so that cycle is a word boundary.
REQ-016 LOCKED: word counter counts 0..WIDTH/2-1; at each wrap the latched-phase window is registered to DATA and DATA_VALID pulses next cycle (latency 1 cycle after last bit of word).
REQ-017 SHALL emit the comma word that caused lock as the first DATA word, DATA_VALID one cycle after lock.
REQ-018 LOCKED: comma in latched phase at a word boundary clears the timeout counter; each other boundary increments it.
REQ-019 Timeout counter reaching COMMA_TIMEOUT -> SEARCH, LOCKED low next cycle, no DATA_VALID that cycle.
REQ-020 Misaligned commas while LOCKED SHALL be ignored (no realignment).
REQ-021 RESYNC SHALL force SEARCH next cycle from any state, overriding a simultaneous comma or boundary; no DATA_VALID that cycle.
REQ-022 DATA_VALID SHALL never assert in SEARCH; DATA holds last word between strobes.

Reset
REQ-023 RST_N low SHALL asynchronously clear shift register, DATA, DATA_VALID, LOCKED, counters, LOSS_CNT and set state SEARCH.
REQ-024 Reset deassertion mid-stream SHALL resume in SEARCH; first DATA_VALID only after a fresh comma.

Configuration
REQ-025 With IDDR_DESER_LOSS_CNT_EN defined, LOSS_CNT SHALL increment (saturating at 255) on each LOCKED->SEARCH transition caused by timeout or RESYNC.
REQ-026 Without IDDR_DESER_LOSS_CNT_EN, LOSS_CNT SHALL be tied to 0 and no counter logic synthesized.

Structure
REQ-027 Comma patterns (both disparities) and state encodings SHALL live in shared package iddr_deser_pkg.
REQ-028 Phase-window comparison SHALL be sub-module iddr_comma_det (window in, match out, combinational).

Verification
REQ-029 Stream K28.5 (0011111010) at phase 0 then 0x155-pattern words -> LOCKED in cycle after comma, DATA=0x0FA then words, DATA_VALID every 5 cycles.
REQ-030 Same stream offset by 1 bit -> lock at phase 1, identical DATA sequence.
REQ-031 Locked, no further commas for 1024 words -> LOCKED drops, DATA_VALID stops, LOSS_CNT=1 (macro on) / 0 (macro off).
REQ-032 RESYNC pulse coinciding with word boundary -> no DATA_VALID that cycle, state SEARCH, relock on next comma.
REQ-033 Misaligned comma injected while LOCKED -> alignment and DATA_VALID cadence unchanged.
REQ-034 RST_N low mid-word -> all outputs 0 immediately; after release no DATA_VALID until comma.

Source files
------------

// File: rtl/iddr_deser_pkg.sv
// iddr_deser_pkg: K28.5 comma patterns and alignment FSM states shared by the DDR deserializer
package iddr_deser_pkg;
  localparam logic [9:0] K28_5_NEG = 10'b0011111010;
  localparam logic [9:0] K28_5_POS = 10'b1100000101;
  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;
endpackage

// File: rtl/iddr_comma_det.sv
// iddr_comma_det: combinational K28.5 match (either disparity) on one bit-phase window
module iddr_comma_det
  import iddr_deser_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] win_i,
  output logic             match_o
);
  localparam int N = WIDTH < 10 ? WIDTH : 10;
  logic [N-1:0] tail;
  assign tail    = win_i[N-1:0];
  assign match_o = (tail == K28_5_NEG[9-:N]) || (tail == K28_5_POS[9-:N]);
endmodule

// File: rtl/iddr_deser.sv
// iddr_deser: DDR sample pair deserializer with K28.5 word alignment; IDDR_DESER_LOSS_CNT_EN adds a lock-loss counter
module iddr_deser
  import iddr_deser_pkg::*;
#(
  parameter int WIDTH         = 10,
  parameter int COMMA_TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             DDR_Q1,
  input  logic             DDR_Q2,
  input  logic             RESYNC,
  output logic [WIDTH-1:0] DATA,
  output logic             DATA_VALID,
  output logic             LOCKED,
  output logic [7:0]       LOSS_CNT
);
  localparam int HW = WIDTH / 2;
  localparam int CW = $clog2(HW);
  localparam int TW = $clog2(COMMA_TIMEOUT + 1);
  state_e           state_q, state_d;
  logic [WIDTH:0]   sr_q, sr_d;
  logic             phase_q, phase_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    to_q, to_d, to_inc;
  logic [WIDTH-1:0] data_q, data_d, win0, win1, sel;
  logic             valid_q, valid_d;
  logic             c0, c1, csel, boundary, tmo, acquire;
  assign win0 = sr_q[WIDTH-1:0];
  assign win1 = sr_q[WIDTH:1];
  iddr_comma_det #(.WIDTH(WIDTH)) u_det0 (.win_i(win0), .match_o(c0));
  iddr_comma_det #(.WIDTH(WIDTH)) u_det1 (.win_i(win1), .match_o(c1));
  assign sel      = phase_q ? win1 : win0;
  assign csel     = phase_q ? c1 : c0;
  assign boundary = (state_q == ST_LOCKED) && (cnt_q == CW'(HW - 1));
  assign to_inc   = to_q + 1'b1;
  assign tmo      = !csel && (to_inc == TW'(COMMA_TIMEOUT));
  assign acquire  = (state_q == ST_SEARCH) && (c0 || c1);
  // alignment state register
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state_q <= ST_SEARCH;
    else state_q <= state_d;
  // resync beats everything, then comma acquisition, then comma timeout at a word boundary
  always_comb
    state_d = RESYNC ? ST_SEARCH : acquire ? ST_LOCKED : (boundary && tmo) ? ST_SEARCH : state_q;
  // word counter, timeout counter, phase latch and output word selection
  always_comb begin
    sr_d    = {sr_q[WIDTH-2:0], DDR_Q1, DDR_Q2};
    phase_d = acquire ? (c1 && !c0) : phase_q;
    cnt_d   = (acquire || boundary) ? '0 : (state_q == ST_LOCKED) ? cnt_q + 1'b1 : cnt_q;
    to_d    = (acquire || (boundary && csel)) ? '0 : boundary ? to_inc : to_q;
    valid_d = !RESYNC && (acquire || (boundary && !tmo));
    data_d  = !valid_d ? data_q : acquire ? (c0 ? win0 : win1) : sel;
  end
  // datapath registers
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      sr_q    <= '0;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      to_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  assign DATA       = data_q;
  assign DATA_VALID = valid_q;
  assign LOCKED     = (state_q == ST_LOCKED);
`ifdef IDDR_DESER_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;
  // count every drop out of lock, saturating
  always_comb
    loss_d = (state_q == ST_LOCKED && state_d == ST_SEARCH && loss_q != 8'hFF) ? loss_q + 8'd1 : loss_q;
  // lock-loss counter register
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) loss_q <= '0;
    else loss_q <= loss_d;
  assign LOSS_CNT = loss_q;
`else
  assign LOSS_CNT = 8'd0;
`endif
endmodule

// File: tb/tb_iddr_deser.sv
// tb_iddr_deser: bit-stream reference model checks of iddr_deser alignment, cadence, timeout, resync and reset
module tb_iddr_deser;
  localparam int W  = 10;
  localparam int TO = 1024;
`ifdef IDDR_DESER_LOSS_CNT_EN
  localparam int LOSS_EN = 1;
`else
  localparam int LOSS_EN = 0;
`endif
  localparam logic [W-1:0] KN = 10'b0011111010;
  localparam logic [W-1:0] KP = 10'b1100000101;
  logic CLK = 0, RST_N = 1, DDR_Q1 = 0, DDR_Q2 = 0, RESYNC = 0;
  logic [W-1:0] DATA;
  logic DATA_VALID, LOCKED;
  logic [7:0] LOSS_CNT;
  int checks = 0, errors = 0;
  bit tx[$];
  bit hist[$];
  int n = 0;
  bit m_locked, m_valid;
  int m_phase, m_lock_end, m_to, m_loss;
  logic [W-1:0] m_data;
  iddr_deser #(.WIDTH(W), .COMMA_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .DDR_Q1(DDR_Q1), .DDR_Q2(DDR_Q2), .RESYNC(RESYNC),
    .DATA(DATA), .DATA_VALID(DATA_VALID), .LOCKED(LOCKED), .LOSS_CNT(LOSS_CNT)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] win(input int p);
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[i] = hist[hist.size() - 1 - p - i];
    return w;
  endfunction
  function automatic bit is_comma(input logic [W-1:0] w);
    return w == KN || w == KP;
  endfunction
  task automatic put(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) tx.push_back(w[i]);
  endtask
  task automatic model_reset();
    hist.delete();
    repeat (W + 1) hist.push_back(1'b0);
    m_locked = 0; m_valid = 0; m_data = '0; m_loss = 0; m_to = 0;
  endtask
  task automatic cyc(input bit rs);
    bit b1, b2, c0, c1;
    logic [W-1:0] w;
    int e;
    @(negedge CLK);
    b1 = tx.size() != 0 ? tx.pop_front() : bit'(n % 2);
    b2 = tx.size() != 0 ? tx.pop_front() : bit'((n + 1) % 2);
    DDR_Q1 = b1; DDR_Q2 = b2; RESYNC = rs;
    c0 = is_comma(win(0));
    c1 = is_comma(win(1));
    m_valid = 0;
    if (rs) begin
      if (m_locked && m_loss < 255) m_loss++;
      m_locked = 0;
    end else if (!m_locked) begin
      if (c0 || c1) begin
        m_phase = c0 ? 0 : 1;
        m_lock_end = n - 1 - m_phase;
        m_data = win(m_phase);
        m_valid = 1; m_locked = 1; m_to = 0;
      end
    end else begin
      e = n - 1 - m_phase;
      if ((e - m_lock_end) % W == 0) begin
        w = win(m_phase);
        m_to = is_comma(w) ? 0 : m_to + 1;
        if (m_to == TO) begin
          m_locked = 0;
          if (m_loss < 255) m_loss++;
        end else begin
          m_data = w; m_valid = 1;
        end
      end
    end
    hist.push_back(b1); hist.push_back(b2); n += 2;
    while (hist.size() > W + 1) void'(hist.pop_front());
    @(posedge CLK); #1;
    RESYNC = 0;
    chk("valid", DATA_VALID, m_valid);
    chk("locked", LOCKED, m_locked);
    chk("data", DATA, m_data);
    chk("loss", LOSS_CNT, LOSS_EN ? m_loss : 0);
  endtask
  task automatic do_reset();
    #1 RST_N = 0;
    #1;
    chk("rst_data", DATA, 0);
    chk("rst_valid", DATA_VALID, 0);
    chk("rst_locked", LOCKED, 0);
    chk("rst_loss", LOSS_CNT, 0);
    @(posedge CLK);
    #2 RST_N = 1;
    model_reset();
  endtask
  task automatic flush();
    while (tx.size() != 0) cyc(0);
  endtask
  task automatic expect_lock(input string tag);
    int i;
    i = 0;
    do begin cyc(0); i++; end while (!DATA_VALID && i < 20);
    chk({tag, "_valid"}, DATA_VALID, 1);
    chk({tag, "_locked"}, LOCKED, 1);
    chk({tag, "_data"}, DATA, 10'h0FA);
  endtask
  initial begin
    int cnt;
    model_reset();
    do_reset();
    repeat (6) cyc(0);
    // phase-0 comma followed by 0x155 words
    put(KN); repeat (8) put(10'h155);
    expect_lock("ph0");
    flush();
    repeat (10) cyc(0);
    // same stream one bit later locks at phase 1
    cyc(1);
    tx.push_back(1'b1); put(KN); repeat (8) put(10'h155);
    expect_lock("ph1");
    flush();
    // misaligned comma while locked leaves cadence unchanged
    tx.push_back(1'b0); tx.push_back(1'b1); tx.push_back(1'b0);
    put(KN); repeat (6) put(10'h155);
    cnt = 0;
    repeat (50) begin cyc(0); cnt += DATA_VALID; end
    chk("misalign_cadence", cnt, 10);
    chk("misalign_locked", LOCKED, 1);
    flush();
    // resync on a word boundary
    cyc(1);
    put(KN); expect_lock("pre_rs");
    repeat (4) cyc(0);
    cyc(1);
    chk("rs_valid", DATA_VALID, 0);
    chk("rs_locked", LOCKED, 0);
    chk("rs_hold", DATA, 10'h0FA);
    put(KN); repeat (2) put(10'h155);
    expect_lock("relock");
    // randomized streams with commas of both disparities and sporadic resync
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 9)) tx.push_back(bit'($urandom_range(0, 1)));
      put($urandom_range(0, 1) ? KN : KP);
      for (int k = 0; k < 20; k++)
        put($urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? KN : KP) : W'($urandom));
      while (tx.size() != 0) cyc($urandom_range(0, 59) == 0);
    end
    // reset mid-word, then silence until a fresh comma
    cyc(1);
    put(KN); repeat (3) put(10'h155);
    expect_lock("pre_rst");
    cyc(0); cyc(0);
    do_reset();
    cnt = 0;
    repeat (30) begin cyc(0); cnt += DATA_VALID; end
    chk("post_rst_quiet", cnt, 0);
    put(KN);
    expect_lock("post_rst");
    // no further commas: timeout drops lock
    cnt = 0;
    for (int i = 0; i < TO * W / 2 + 20 && LOCKED; i++) begin cyc(0); cnt += DATA_VALID; end
    chk("tmo_locked", LOCKED, 0);
    chk("tmo_words", cnt, TO - 1);
    chk("tmo_loss", LOSS_CNT, LOSS_EN);
    cnt = 0;
    repeat (20) begin cyc(0); cnt += DATA_VALID; end
    chk("tmo_quiet", cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
